// File: rtl/dh_check_pkg.sv
// Shared types and constants for the DH key-confirmation response checker.
package dh_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam int FAIL_CNT_W   = 8;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_TIMEOUT  = 1024;
  localparam int DEF_MAX_FAIL = 3;

  // Failure count holds at all-ones instead of wrapping back to zero.
  function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
    return (v == '1) ? v : v + FAIL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/dh_check_timer.sv
// Response-wait timer: loadable up-counter that flags the last allowed cycle.
module dh_check_timer
  import dh_check_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      logic [TMR_W-1:0] count;

      // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count <= '0;
        end else if (load) begin
          count <= '0;
        end else if (en) begin
          count <= count + TMR_W'(1);
        end
      end

      assign expire = (count == TMR_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/dh_response_checker.sv
// Single-response key-confirmation checker: accepts c, compares c^k against the
// expected nonce r, publishes pass/fail/timeout and locks out after repeated failures.
module dh_response_checker
  import dh_check_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_FAIL = DEF_MAX_FAIL,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int TMR_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm_i,
  input  logic [DATA_W-1:0]     r_i,
  input  logic [DATA_W-1:0]     k_i,
  input  logic                  resp_valid_i,
  input  logic [DATA_W-1:0]     c_i,
  output logic                  resp_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic                  locked_o,
  output logic [FAIL_CNT_W-1:0] fail_cnt_o,
  input  logic                  unlock_i
);

  state_t                  state, state_n;
  logic [DATA_W-1:0]       r_reg, k_reg, x_reg;
  logic [FAIL_CNT_W-1:0]   fail_cnt, cnt_base, cnt_n;
  logic                    pass_q, fail_q, timeout_q, done_q;

  logic hs, tmo, load_rk, tmr_load, tmr_en, publish, pub_match, lock_hit, expire;

  dh_check_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .en     (tmr_en),
    .expire (expire)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    hs        = 1'b0;
    tmo       = 1'b0;
    load_rk   = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    publish   = 1'b0;
    pub_match = 1'b0;

    unique case (state)
      IDLE: begin
        if (arm_i) begin
          load_rk  = 1'b1;
          tmr_load = 1'b1;
          state_n  = ARMED;
        end
      end
      ARMED: begin
        // A response beats both a re-arm and an expiry landing on the same cycle.
        if (resp_valid_i) begin
          hs      = 1'b1;
          state_n = CHECK;
        end else if (arm_i) begin
          load_rk  = 1'b1;
          tmr_load = 1'b1;
        end else if (expire) begin
          tmo     = 1'b1;
          publish = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      CHECK: begin
        publish   = 1'b1;
        pub_match = (x_reg == r_reg);
      end
      LOCKED: begin
        if (unlock_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    cnt_base = unlock_i ? '0 : fail_cnt;
    if (publish) cnt_n = pub_match ? '0 : sat_inc(cnt_base);
    else         cnt_n = cnt_base;

    lock_hit = publish && !pub_match && (cnt_n >= FAIL_CNT_W'(MAX_FAIL));
    if (publish) state_n = lock_hit ? LOCKED : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r_reg     <= '0;
      k_reg     <= '0;
      x_reg     <= '0;
      fail_cnt  <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state    <= state_n;
      fail_cnt <= cnt_n;
      done_q   <= publish;
      if (load_rk) begin
        r_reg     <= r_i;
        k_reg     <= k_i;
        pass_q    <= 1'b0;
        fail_q    <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (hs) x_reg <= c_i ^ k_reg;
      if (publish) begin
        pass_q    <= pub_match;
        fail_q    <= !pub_match;
        timeout_q <= tmo;
      end
    end
  end

  assign resp_ready_o = (state == ARMED);
  assign busy_o       = (state != IDLE);
  assign locked_o     = (state == LOCKED);
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign fail_o       = fail_q;
  assign timeout_o    = timeout_q;
  assign fail_cnt_o   = fail_cnt;

endmodule

// File: tb/tb_dh_response_checker.sv
// Directed bench for dh_response_checker with TIMEOUT=16 and MAX_FAIL=3.
module tb_dh_response_checker;

  localparam int DATA_W   = 64;
  localparam int MAX_FAIL = 3;
  localparam int TIMEOUT  = 16;

  localparam logic [63:0] R_A = 64'h0123456789ABCDEF;
  localparam logic [63:0] K_A = 64'hFFFF0000FFFF0000;
  localparam logic [63:0] C_A = 64'hFEDC45677654CDEF; // R_A ^ K_A

  logic              clk, rst, arm_i, resp_valid_i, unlock_i;
  logic [DATA_W-1:0] r_i, k_i, c_i;
  logic              resp_ready_o, busy_o, done_o, pass_o, fail_o, timeout_o, locked_o;
  logic [7:0]        fail_cnt_o;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int d0;

  dh_response_checker #(
    .DATA_W   (DATA_W),
    .MAX_FAIL (MAX_FAIL),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm_i        (arm_i),
    .r_i          (r_i),
    .k_i          (k_i),
    .resp_valid_i (resp_valid_i),
    .c_i          (c_i),
    .resp_ready_o (resp_ready_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .fail_o       (fail_o),
    .timeout_o    (timeout_o),
    .locked_o     (locked_o),
    .fail_cnt_o   (fail_cnt_o),
    .unlock_i     (unlock_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done_o) done_seen++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Arm, present c one cycle later, and stop right after the publish edge.
  task automatic run_check(input logic [63:0] r, input logic [63:0] k, input logic [63:0] c);
    arm_i = 1'b1; r_i = r; k_i = k;
    step(1);
    arm_i = 1'b0; resp_valid_i = 1'b1; c_i = c;
    step(1);
    resp_valid_i = 1'b0;
    step(1);
  endtask

  initial begin
    rst = 1'b1; arm_i = 1'b0; resp_valid_i = 1'b0; unlock_i = 1'b0;
    r_i = '0; k_i = '0; c_i = '0;
    step(2);
    check("reset_outputs", {resp_ready_o, busy_o, done_o, pass_o, fail_o, timeout_o, locked_o, fail_cnt_o}, '0);
    rst = 1'b0;
    step(1);

    // Responses offered in IDLE are ignored.
    d0 = done_seen;
    resp_valid_i = 1'b1; c_i = C_A;
    step(3);
    check("idle_ready", resp_ready_o, 1'b0);
    check("idle_busy", busy_o, 1'b0);
    resp_valid_i = 1'b0;
    step(1);
    check("idle_no_done", done_seen - d0, 0);

    // Pass path with latency check.
    arm_i = 1'b1; r_i = R_A; k_i = K_A;
    step(1);
    arm_i = 1'b0;
    check("armed_ready", resp_ready_o, 1'b1);
    resp_valid_i = 1'b1; c_i = C_A;
    step(1);
    resp_valid_i = 1'b0;
    check("pass_not_yet", {done_o, busy_o}, 2'b01);
    step(1);
    check("pass_flags", {done_o, pass_o, fail_o, timeout_o}, 4'b1100);
    check("pass_cnt", fail_cnt_o, 0);
    step(1);
    check("pass_done_pulse", {done_o, busy_o}, 2'b00);

    // Timeout with no response.
    arm_i = 1'b1;
    step(1);
    arm_i = 1'b0;
    step(TIMEOUT - 1);
    check("tmo_wait", {done_o, busy_o}, 2'b01);
    step(1);
    check("tmo_flags", {done_o, pass_o, fail_o, timeout_o, busy_o}, 5'b10110);
    check("tmo_cnt", fail_cnt_o, 1);

    // Response on the expiry cycle wins over the timeout.
    arm_i = 1'b1; r_i = R_A; k_i = K_A;
    step(1);
    arm_i = 1'b0;
    step(TIMEOUT - 1);
    resp_valid_i = 1'b1; c_i = C_A;
    step(1);
    resp_valid_i = 1'b0;
    check("expiry_hs_no_tmo", {done_o, busy_o}, 2'b01);
    step(1);
    check("expiry_hs_flags", {done_o, pass_o, fail_o, timeout_o}, 4'b1100);
    check("expiry_hs_cnt", fail_cnt_o, 0);

    // Re-arm before the response: second r/k pair is the one checked.
    step(1);
    d0 = done_seen;
    arm_i = 1'b1; r_i = 64'd5; k_i = 64'hA5A5;
    step(1);
    r_i = 64'd9;
    step(1);
    arm_i = 1'b0; r_i = 64'd5;
    check("rearm_no_done", done_o, 1'b0);
    resp_valid_i = 1'b1; c_i = 64'hA5AC;
    step(1);
    resp_valid_i = 1'b0;
    step(1);
    check("rearm_pass", {done_o, pass_o, fail_o}, 3'b110);
    check("rearm_cnt", fail_cnt_o, 0);
    step(1);
    check("rearm_one_done", done_seen - d0, 1);

    // A pass after two fails clears the count.
    run_check(R_A, K_A, 64'd0);
    check("cnt_fail1", fail_cnt_o, 1);
    step(1);
    run_check(R_A, K_A, 64'd0);
    check("cnt_fail2", {fail_o, fail_cnt_o}, {1'b1, 8'd2});
    step(1);
    run_check(R_A, K_A, C_A);
    check("cnt_pass_clears", {pass_o, fail_o, fail_cnt_o}, {2'b10, 8'd0});
    step(1);

    // unlock outside LOCKED clears only the count.
    run_check(R_A, K_A, 64'd0);
    step(1);
    unlock_i = 1'b1;
    step(1);
    unlock_i = 1'b0;
    check("unlock_idle", {fail_o, busy_o, fail_cnt_o}, {2'b10, 8'd0});

    // Lockout after three consecutive mismatches.
    run_check(R_A, K_A, 64'd0);
    check("lock_cnt1", {locked_o, fail_cnt_o}, {1'b0, 8'd1});
    step(1);
    run_check(R_A, K_A, 64'd0);
    check("lock_cnt2", {locked_o, fail_cnt_o}, {1'b0, 8'd2});
    step(1);
    run_check(R_A, K_A, 64'd0);
    check("lock_cnt3", {done_o, fail_o, fail_cnt_o}, {2'b11, 8'd3});
    check("locked_state", {locked_o, resp_ready_o, busy_o}, 3'b101);
    arm_i = 1'b1; resp_valid_i = 1'b1;
    step(2);
    arm_i = 1'b0; resp_valid_i = 1'b0;
    check("locked_ignores_arm", {locked_o, resp_ready_o, busy_o, done_o}, 4'b1010);
    unlock_i = 1'b1;
    step(1);
    unlock_i = 1'b0;
    check("unlock_locked", {locked_o, busy_o, fail_o, fail_cnt_o}, {3'b001, 8'd0});

    // Reset while in CHECK: everything clears at once, no result is published.
    arm_i = 1'b1; r_i = R_A; k_i = K_A;
    step(1);
    arm_i = 1'b0; resp_valid_i = 1'b1; c_i = C_A;
    step(1);
    resp_valid_i = 1'b0;
    check("in_check", {busy_o, resp_ready_o}, 2'b10);
    d0 = done_seen;
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {resp_ready_o, busy_o, done_o, pass_o, fail_o, timeout_o, locked_o, fail_cnt_o}, '0);
    step(2);
    rst = 1'b0;
    step(2);
    check("rst_mid_no_done", done_seen - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
